// File: rtl/regfile_pkg.sv
// Shared defaults and types for the register file with busy scoreboard.
package regfile_pkg;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_ADDR_W = 5;
   localparam int unsigned ZERO_ADDR  = 0;

   typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
   typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for long-latency results: issue acceptance, set/clear, busy read ports.
module rf_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              iss_en_i,
   input  logic [ADDR_W-1:0] iss_addr_i,
   output logic              iss_ok_o,
   input  logic              cmp_en_i,
   input  logic [ADDR_W-1:0] cmp_addr_i,
   input  logic [ADDR_W-1:0] rs_addr_i,
   input  logic [ADDR_W-1:0] rt_addr_i,
   output logic              rs_busy_o,
   output logic              rt_busy_o
);

   localparam int unsigned NReg = 2 ** ADDR_W;

   logic [NReg-1:0] busy_q, busy_d;
   logic            iss_zero, rs_zero, rt_zero;

   assign iss_zero = ZERO_REG && (iss_addr_i == ADDR_W'(ZERO_ADDR));
   assign rs_zero  = ZERO_REG && (rs_addr_i == ADDR_W'(ZERO_ADDR));
   assign rt_zero  = ZERO_REG && (rt_addr_i == ADDR_W'(ZERO_ADDR));

   assign iss_ok_o = rst && iss_en_i && !busy_q[iss_addr_i] && !iss_zero;

   // Set after clear so a same-cycle issue to a completing register stays busy.
   always_comb begin
      busy_d = busy_q;
      if (cmp_en_i) busy_d[cmp_addr_i] = 1'b0;
      if (iss_ok_o) busy_d[iss_addr_i] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) busy_q <= '0;
      else      busy_q <= busy_d;
   end

   always_comb begin
      rs_busy_o = busy_q[rs_addr_i];
      rt_busy_o = busy_q[rt_addr_i];
      if (!rst || rs_zero || (cmp_en_i && (cmp_addr_i == rs_addr_i))) rs_busy_o = 1'b0;
      if (!rst || rt_zero || (cmp_en_i && (cmp_addr_i == rt_addr_i))) rt_busy_o = 1'b0;
   end

endmodule

// File: rtl/regfile_sb.sv
// Two-read, two-write register file: pipeline write port, handshaked coprocessor
// write port, optional zero register and write-to-read bypass, busy scoreboard.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rs_addr_i,
   input  logic [ADDR_W-1:0] rt_addr_i,
   output logic [DATA_W-1:0] rs_data_o,
   output logic [DATA_W-1:0] rt_data_o,
   output logic              rs_busy_o,
   output logic              rt_busy_o,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              iss_en_i,
   input  logic [ADDR_W-1:0] iss_addr_i,
   output logic              iss_ok_o,
   input  logic              lw_valid_i,
   input  logic [ADDR_W-1:0] lw_addr_i,
   input  logic [DATA_W-1:0] lw_data_i,
   output logic              lw_ready_o
);

   localparam int unsigned NReg = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [NReg];
   logic [DATA_W-1:0] mem_d [NReg];
   logic              lw_acc;
   logic              wr_zero, lw_zero, rs_zero, rt_zero;

   // Pipeline wins a same-address collision; coprocessor holds and retries.
   assign lw_ready_o = rst && !(wr_en_i && (wr_addr_i == lw_addr_i));
   assign lw_acc     = lw_valid_i && lw_ready_o;

   assign wr_zero = ZERO_REG && (wr_addr_i == ADDR_W'(ZERO_ADDR));
   assign lw_zero = ZERO_REG && (lw_addr_i == ADDR_W'(ZERO_ADDR));
   assign rs_zero = ZERO_REG && (rs_addr_i == ADDR_W'(ZERO_ADDR));
   assign rt_zero = ZERO_REG && (rt_addr_i == ADDR_W'(ZERO_ADDR));

   always_comb begin
      mem_d = mem_q;
      if (lw_acc && !lw_zero)  mem_d[lw_addr_i] = lw_data_i;
      if (wr_en_i && !wr_zero) mem_d[wr_addr_i] = wr_data_i;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NReg; i++) mem_q[i] <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   // Later assignments take priority: coprocessor bypass over pipeline bypass over array.
   always_comb begin
      rs_data_o = mem_q[rs_addr_i];
      rt_data_o = mem_q[rt_addr_i];
      if (BYPASS && wr_en_i && (wr_addr_i == rs_addr_i)) rs_data_o = wr_data_i;
      if (BYPASS && wr_en_i && (wr_addr_i == rt_addr_i)) rt_data_o = wr_data_i;
      if (BYPASS && lw_acc && (lw_addr_i == rs_addr_i))  rs_data_o = lw_data_i;
      if (BYPASS && lw_acc && (lw_addr_i == rt_addr_i))  rt_data_o = lw_data_i;
      if (!rst || rs_zero) rs_data_o = '0;
      if (!rst || rt_zero) rt_data_o = '0;
   end

   rf_scoreboard #(
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG)
   ) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .iss_en_i  (iss_en_i),
      .iss_addr_i(iss_addr_i),
      .iss_ok_o  (iss_ok_o),
      .cmp_en_i  (lw_acc),
      .cmp_addr_i(lw_addr_i),
      .rs_addr_i (rs_addr_i),
      .rt_addr_i (rt_addr_i),
      .rs_busy_o (rs_busy_o),
      .rt_busy_o (rt_busy_o)
   );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic
// compared against an array-based reference model.
module tb_regfile_sb;

   logic        clk;
   logic        rst;
   logic [4:0]  rs_addr, rt_addr, wr_addr, iss_addr, lw_addr;
   logic [31:0] rs_data, rt_data, wr_data, lw_data;
   logic        rs_busy, rt_busy, wr_en, iss_en, iss_ok, lw_valid, lw_ready;

   logic [31:0] m_mem  [32];
   bit          m_busy [32];

   int n_checks = 0;
   int n_fail   = 0;

   regfile_sb dut (
      .clk       (clk),
      .rst       (rst),
      .rs_addr_i (rs_addr),
      .rt_addr_i (rt_addr),
      .rs_data_o (rs_data),
      .rt_data_o (rt_data),
      .rs_busy_o (rs_busy),
      .rt_busy_o (rt_busy),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .iss_en_i  (iss_en),
      .iss_addr_i(iss_addr),
      .iss_ok_o  (iss_ok),
      .lw_valid_i(lw_valid),
      .lw_addr_i (lw_addr),
      .lw_data_i (lw_data),
      .lw_ready_o(lw_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic bit m_ready();
      return !(wr_en && wr_addr == lw_addr);
   endfunction

   function automatic bit m_acc();
      return lw_valid && m_ready();
   endfunction

   function automatic bit m_iss_ok();
      return iss_en && !m_busy[iss_addr] && iss_addr != 0;
   endfunction

   function automatic logic [31:0] m_data(input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (m_acc() && lw_addr == a) return lw_data;
      if (wr_en && wr_addr == a) return wr_data;
      return m_mem[a];
   endfunction

   function automatic bit m_rbusy(input logic [4:0] a);
      if (a == 0) return 1'b0;
      if (m_acc() && lw_addr == a) return 1'b0;
      return m_busy[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_mem[i]  = '0;
         m_busy[i] = 1'b0;
      end
   endtask

   task automatic idle();
      wr_en = 0; wr_addr = 0; wr_data = 0;
      iss_en = 0; iss_addr = 0;
      lw_valid = 0; lw_addr = 0; lw_data = 0;
   endtask

   // Called at a negedge with inputs driven: check all outputs, clock once, update model.
   task automatic cycle();
      bit acc, ok;
      #1;
      acc = m_acc();
      ok  = m_iss_ok();
      check_eq("rs_data", rs_data, m_data(rs_addr));
      check_eq("rt_data", rt_data, m_data(rt_addr));
      check_eq("rs_busy", 32'(rs_busy), 32'(m_rbusy(rs_addr)));
      check_eq("rt_busy", 32'(rt_busy), 32'(m_rbusy(rt_addr)));
      check_eq("iss_ok", 32'(iss_ok), 32'(ok));
      check_eq("lw_ready", 32'(lw_ready), 32'(m_ready()));
      @(posedge clk);
      if (acc && lw_addr != 0) m_mem[lw_addr] = lw_data;
      if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
      if (acc) m_busy[lw_addr] = 1'b0;
      if (ok) m_busy[iss_addr] = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      bit hold;
      rst = 0; rs_addr = 0; rt_addr = 0;
      idle();
      model_reset();
      iss_en = 1; iss_addr = 2; lw_valid = 1; lw_addr = 6; rs_addr = 6; rt_addr = 2;
      repeat (2) @(negedge clk);
      #1;
      check_eq("rst_rs_data", rs_data, 0);
      check_eq("rst_rs_busy", 32'(rs_busy), 0);
      check_eq("rst_iss_ok", 32'(iss_ok), 0);
      check_eq("rst_lw_ready", 32'(lw_ready), 0);
      idle();
      @(negedge clk);
      rst = 1;

      // Pipeline write and bypass
      wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; rs_addr = 5;
      #1 check_eq("r5_bypass", rs_data, 32'hDEADBEEF);
      cycle();
      idle();
      #1 check_eq("r5_array", rs_data, 32'hDEADBEEF);
      cycle();

      // Zero register
      wr_en = 1; wr_addr = 0; wr_data = 32'h1234; rs_addr = 0;
      cycle();
      idle(); iss_en = 1; iss_addr = 0;
      #1 check_eq("r0_read", rs_data, 0);
      check_eq("r0_iss", 32'(iss_ok), 0);
      cycle();

      // Issue / refuse / complete on r9
      idle(); iss_en = 1; iss_addr = 9; rt_addr = 9;
      #1 check_eq("r9_iss_ok", 32'(iss_ok), 1);
      cycle();
      #1 check_eq("r9_busy", 32'(rt_busy), 1);
      check_eq("r9_iss_refused", 32'(iss_ok), 0);
      cycle();
      idle(); lw_valid = 1; lw_addr = 9; lw_data = 32'hA5A5A5A5;
      #1 check_eq("r9_lw_ready", 32'(lw_ready), 1);
      check_eq("r9_busy_bypass", 32'(rt_busy), 0);
      check_eq("r9_data_bypass", rt_data, 32'hA5A5A5A5);
      cycle();

      // Same-address collision on r7
      idle(); rs_addr = 7;
      wr_en = 1; wr_addr = 7; wr_data = 32'h11;
      lw_valid = 1; lw_addr = 7; lw_data = 32'h22;
      #1 check_eq("r7_lw_blocked", 32'(lw_ready), 0);
      check_eq("r7_pipe_wins", rs_data, 32'h11);
      cycle();
      wr_en = 0;
      #1 check_eq("r7_lw_retry", 32'(lw_ready), 1);
      cycle();
      idle();
      #1 check_eq("r7_final", rs_data, 32'h22);
      cycle();

      // Issue and completion to r3 in one cycle
      iss_en = 1; iss_addr = 3; lw_valid = 1; lw_addr = 3; lw_data = 32'h33; rs_addr = 3;
      cycle();
      idle();
      #1 check_eq("r3_busy_kept", 32'(rs_busy), 1);
      cycle();
      lw_valid = 1; lw_addr = 3; lw_data = 32'h34;
      cycle();

      // Reset mid-operation with r4 busy
      idle(); iss_en = 1; iss_addr = 4; rs_addr = 4;
      cycle();
      idle(); wr_en = 1; wr_addr = 4; wr_data = 32'h55;
      cycle();
      idle();
      #1 check_eq("r4_busy", 32'(rs_busy), 1);
      check_eq("r4_data", rs_data, 32'h55);
      lw_valid = 1; lw_addr = 4; lw_data = 32'h99;
      rst = 0;
      #1 check_eq("mid_rst_data", rs_data, 0);
      check_eq("mid_rst_busy", 32'(rs_busy), 0);
      check_eq("mid_rst_lw_ready", 32'(lw_ready), 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      #1 check_eq("mid_rst_lw_hold", 32'(lw_ready), 0);
      check_eq("mid_rst_data2", rs_data, 0);
      idle();
      rst = 1;
      #1 check_eq("post_rst_busy", 32'(rs_busy), 0);
      cycle();

      // Randomized traffic; coprocessor holds its request until accepted
      hold = 0;
      for (int n = 0; n < 400; n++) begin
         wr_en    = ($urandom_range(0, 2) == 0);
         wr_addr  = 5'($urandom_range(0, 7));
         wr_data  = $urandom;
         iss_en   = ($urandom_range(0, 2) == 0);
         iss_addr = 5'($urandom_range(0, 7));
         if (!hold) begin
            lw_valid = ($urandom_range(0, 1) == 0);
            lw_addr  = 5'($urandom_range(0, 7));
            lw_data  = $urandom;
         end
         rs_addr = 5'($urandom_range(0, 7));
         rt_addr = 5'($urandom_range(0, 7));
         #1 hold = lw_valid && !m_acc();
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
